// File: rtl/qspi_cmd_parser_pkg.sv
// Shared types and constants for the QSPI command parser.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: word width, opcode values, parser state enum.
package qspi_cmd_pkg;

  localparam int WORD_BITS = 16;

  localparam logic [7:0] OP_WRITE_MEM = 8'h01;
  localparam logic [7:0] OP_WRITE_REG = 8'h02;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR_HI,
    ST_ADDR_LO,
    ST_LEN,
    ST_PAYLOAD,
    ST_REG_HI,
    ST_REG_LO,
    ST_SKIP
  } parser_state_t;

endpackage

// File: rtl/qspi_cmd_parser_if.sv
// Bundle of the QSPI word stream, SDRAM write channel and register strobe.
// Latency: n/a (wires only).
// Backpressure: s_valid/s_ready on the stream, req/ack on the SDRAM side.
// Ports: slave = parser view (consumes stream, drives back end);
//        master = environment view (drives stream, answers ram_ack).
interface qspi_cmd_parser_if #(
  parameter int ADDR_BITS = 22
) ();
  import qspi_cmd_pkg::*;

  logic                 start;
  logic [WORD_BITS-1:0] s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic                 ram_req;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [WORD_BITS-1:0] ram_wdata;
  logic                 ram_ack;
  logic                 reg_wr;
  logic [3:0]           reg_addr;
  logic [31:0]          reg_data;
  logic                 err_cmd;
  logic                 busy;

  modport slave (
    input  start, s_data, s_valid, ram_ack,
    output s_ready, ram_req, ram_addr, ram_wdata,
           reg_wr, reg_addr, reg_data, err_cmd, busy
  );

  modport master (
    output start, s_data, s_valid, ram_ack,
    input  s_ready, ram_req, ram_addr, ram_wdata,
           reg_wr, reg_addr, reg_data, err_cmd, busy
  );

endinterface

// File: rtl/qspi_cmd_parser_fifo.sv
// Single-clock FIFO, first-word-fall-through read port (dout = head).
// Latency: a pushed word is visible on dout after the push edge.
// Backpressure: caller honours full/empty; push on full is legal only with pop.
// Ports: clk, rst_n (async active-low), push/din, pop/dout, full, empty.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // When full, the slot being written is the one being popped this edge.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/qspi_cmd_parser.sv
// Decodes framed QSPI commands into SDRAM single-word writes and register strobes.
// Latency: payload word -> ram_req one edge after push; DATA_LO -> reg_wr next cycle.
// Backpressure: s_ready low in LEN until drained, and in PAYLOAD while the FIFO is full.
// Ports: clk, async_nreset (async active-low), bus (qspi_cmd_parser_if.slave).
module qspi_cmd_parser
  import qspi_cmd_pkg::*;
#(
  parameter int ADDR_BITS  = 22,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  async_nreset,
  qspi_cmd_parser_if.slave      bus
);

  localparam int HI_BITS = ADDR_BITS - 16;

  parser_state_t        state;
  parser_state_t        state_nxt;
  // Low while in reset and for the first cycle after, so s_ready resets to 0
  // even though IDLE otherwise accepts and discards words.
  logic                 live;

  logic                 rdy_dec;
  logic                 s_ready;
  logic                 take;
  logic                 push;
  logic                 pop;
  logic                 load_addr;
  logic                 err_nxt;
  logic                 reg_wr_nxt;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic [WORD_BITS-1:0] fifo_dout;

  logic [HI_BITS-1:0]   addr_hi;
  logic [15:0]          addr_lo;
  logic [15:0]          remaining;
  logic [15:0]          data_hi;
  logic [3:0]           reg_idx;

  logic                 ram_req;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [WORD_BITS-1:0] ram_wdata;
  logic                 reg_wr;
  logic [3:0]           reg_addr;
  logic [31:0]          reg_data;
  logic                 err_cmd;

  // Ready is a pure decode of registered state and FIFO flags, never of s_valid.
  always_comb begin
    rdy_dec = 1'b0;
    case (state)
      ST_IDLE, ST_SKIP, ST_CMD, ST_ADDR_HI,
      ST_ADDR_LO, ST_REG_HI, ST_REG_LO: rdy_dec = 1'b1;
      // The address counter is reloaded on LEN, so wait for the old burst to finish.
      ST_LEN:                           rdy_dec = fifo_empty && !ram_req;
      ST_PAYLOAD:                       rdy_dec = !fifo_full;
      default:                          rdy_dec = 1'b0;
    endcase
  end

  assign s_ready = live && rdy_dec;
  // start wins over a word accepted in the same cycle; that word is dropped.
  assign take    = bus.s_valid && s_ready && !bus.start;
  assign pop     = !ram_req && !fifo_empty;

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      state <= ST_IDLE;
      live  <= 1'b0;
    end else begin
      state <= state_nxt;
      live  <= 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    push       = 1'b0;
    load_addr  = 1'b0;
    err_nxt    = 1'b0;
    reg_wr_nxt = 1'b0;
    if (bus.start) begin
      state_nxt = ST_CMD;
    end else if (take) begin
      case (state)
        ST_CMD: begin
          if (bus.s_data[15:8] == OP_WRITE_MEM) begin
            state_nxt = ST_ADDR_HI;
          end else if (bus.s_data[15:8] == OP_WRITE_REG) begin
            state_nxt = ST_REG_HI;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = ST_SKIP;
          end
        end
        ST_ADDR_HI: state_nxt = ST_ADDR_LO;
        ST_ADDR_LO: state_nxt = ST_LEN;
        ST_LEN: begin
          load_addr = 1'b1;
          state_nxt = (bus.s_data == 16'd0) ? ST_IDLE : ST_PAYLOAD;
        end
        ST_PAYLOAD: begin
          push = 1'b1;
          if (remaining == 16'd1) state_nxt = ST_IDLE;
        end
        ST_REG_HI:  state_nxt = ST_REG_LO;
        ST_REG_LO: begin
          reg_wr_nxt = 1'b1;
          state_nxt  = ST_IDLE;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      addr_hi   <= '0;
      addr_lo   <= '0;
      remaining <= '0;
      data_hi   <= '0;
      reg_idx   <= '0;
      reg_wr    <= 1'b0;
      reg_addr  <= '0;
      reg_data  <= '0;
      err_cmd   <= 1'b0;
      ram_req   <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
    end else begin
      reg_wr  <= reg_wr_nxt;
      err_cmd <= err_nxt;
      if (take) begin
        case (state)
          ST_CMD:     reg_idx   <= bus.s_data[3:0];
          ST_ADDR_HI: addr_hi   <= bus.s_data[HI_BITS-1:0];
          ST_ADDR_LO: addr_lo   <= bus.s_data;
          ST_LEN:     remaining <= bus.s_data;
          ST_PAYLOAD: remaining <= remaining - 1'b1;
          ST_REG_HI:  data_hi   <= bus.s_data;
          ST_REG_LO: begin
            reg_data <= {data_hi, bus.s_data};
            reg_addr <= reg_idx;
          end
          default: ;
        endcase
      end
      // Drain: one word in flight at a time; a stray ack while idle is ignored.
      if (ram_req) begin
        if (bus.ram_ack) begin
          ram_req  <= 1'b0;
          ram_addr <= ram_addr + 1'b1;
        end
      end else if (!fifo_empty) begin
        ram_req   <= 1'b1;
        ram_wdata <= fifo_dout;
      end
      // LEN only accepts with nothing in flight, so this never races an increment.
      if (load_addr) ram_addr <= {addr_hi, addr_lo};
    end
  end

  sync_fifo #(
    .WIDTH (WORD_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (async_nreset),
    .push  (push),
    .din   (bus.s_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.s_ready   = s_ready;
  assign bus.ram_req   = ram_req;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_wdata = ram_wdata;
  assign bus.reg_wr    = reg_wr;
  assign bus.reg_addr  = reg_addr;
  assign bus.reg_data  = reg_data;
  assign bus.err_cmd   = err_cmd;
  assign bus.busy      = ((state != ST_IDLE) && (state != ST_SKIP)) || !fifo_empty || ram_req;

endmodule

// File: doc/qspi_cmd_parser.md
# qspi_cmd_parser

Command parser between the `qspi` word stream and the SDRAM/register back end. It consumes 16-bit words from the `qspi` read stream (valid/ready plus a `start` transaction pulse) and decodes framed commands. Memory-write payloads go through an internal FIFO into an SDRAM channel as single-word writes. Register writes are emitted as one-cycle strobes in the `wr_reg`/`wr_reg_addr` form used by `map_mux`.

## Interface
Parameters:
- `ADDR_BITS`, 22: SDRAM word-address width (row+col+bank).
- `FIFO_DEPTH`, 8: payload FIFO depth in words; power of two, ≥2.

Ports:
- `clk`  in  1: system clock (PLL `CLKOP`).
- `async_nreset`  in  1: asynchronous active-low reset.
- `start`  in  1: one-cycle pulse; a new QSPI transaction has begun.
- `s_data`  in  16: word from `qspi`.
- `s_valid`  in  1: `s_data` valid.
- `s_ready`  out  1: word accepted when `s_valid && s_ready`.
- `ram_req`  out  1: SDRAM write request.
- `ram_addr`  out  ADDR_BITS: write word address.
- `ram_wdata`  out  16: write data.
- `ram_ack`  in  1: one-cycle pulse; the current request is done.
- `reg_wr`  out  1: one-cycle register-write strobe.
- `reg_addr`  out  4: register index.
- `reg_data`  out  32: register value.
- `err_cmd`  out  1: one-cycle pulse on an unknown opcode.
- `busy`  out  1: parse in progress, FIFO non-empty, or request outstanding.

## Operation
- Frame layout:
  - Word 0 is the header: `[15:8]` opcode, `[7:0]` argument.
  - `0x01` WRITE_MEM is followed by ADDR_HI (bits above 16 in `[ADDR_BITS-17:0]`), ADDR_LO, LEN (payload word count; 0 means no payload), then LEN payload words.
  - `0x02` WRITE_REG takes `arg[3:0]` as the register index, followed by DATA_HI and DATA_LO.
- Parser states: IDLE, CMD, ADDR_HI, ADDR_LO, LEN, PAYLOAD, REG_HI, REG_LO, SKIP.
- `start` forces CMD from any state. It has priority over a word accepted in the same cycle; that word is dropped.
- In IDLE and SKIP, `s_ready=1` and words are discarded.
- CMD transitions:
  - `0x01` → ADDR_HI.
  - `0x02` → REG_HI.
  - Any other opcode pulses `err_cmd` → SKIP.
- ADDR_HI → ADDR_LO → LEN.
- In LEN, `s_ready=0` until the FIFO is empty and no `ram_req` is outstanding. On accept, the drain-side address counter is loaded.
  - LEN=0 → IDLE.
  - Otherwise → PAYLOAD.
- In PAYLOAD, `s_ready` = FIFO not full. Each accepted word is pushed and decrements the remaining count; the count reaching 0 → IDLE.
- REG_HI latches the high half. REG_LO drives `reg_data={hi,lo}` and `reg_addr`, pulses `reg_wr`, then → IDLE.
- Drain side:
  - When `!ram_req` and the FIFO is non-empty: pop, drive `ram_wdata` and the address, assert `ram_req`.
  - On `ram_ack`: deassert `ram_req` and increment the address modulo 2^ADDR_BITS (wraps silently).
- Truncated frame: `start` arriving mid-PAYLOAD abandons the remaining count, but the FIFO still drains with the old addresses.
- Stray `ram_ack` with `!ram_req` is ignored.

## Timing
- Reset values:
  - `s_ready=0`, `ram_req=0`, `ram_addr=0`, `ram_wdata=0`, `reg_wr=0`, `reg_addr=0`, `reg_data=0`, `err_cmd=0`, `busy=0`.
  - State IDLE, FIFO empty.
- `s_ready` is registered state-decode plus FIFO-full. It may depend combinationally on FIFO occupancy, never on `s_valid`.
- Latencies:
  - A payload word accepted at edge N into an empty FIFO with no request outstanding gives `ram_req=1` after edge N+1.
  - After the `ram_ack` edge, the next request can assert one edge later, i.e. at most one word per 2 cycles plus the ack wait.
  - `reg_wr` is high for exactly the cycle after the DATA_LO accept edge. `reg_data`/`reg_addr` hold until the next `reg_wr`.
- `ram_addr`/`ram_wdata` are stable throughout `ram_req`.
- Simultaneous push and pop on a full FIFO is allowed. `s_ready` uses the pre-pop full flag, so there is no combinational loop.
- Reset mid-operation (asserting `async_nreset` low) clears everything immediately. An in-flight SDRAM request is dropped; the back end is reset by the same PLL lock.

## Structure
- `qspi_cmd_pkg` holds:
  - `OP_WRITE_MEM=8'h01`, `OP_WRITE_REG=8'h02`.
  - The `parser_state_t` enum.
- Sub-module `sync_fifo` (WIDTH=16, DEPTH=FIFO_DEPTH): single clock with push/pop/full/empty. It is reusable by `api`.

## Test plan
- Frame `0101,0003,4000,0002,AAAA,5555` with `ram_ack` 3 cycles after each req: writes AAAA@0x34000 then 5555@0x34001; `busy` falls after the second ack.
- `0207,1234,5678`: single `reg_wr`, `reg_addr=7`, `reg_data=0x12345678`, no `ram_req`.
- `ram_ack` held off 50 cycles with a 12-word payload: `s_ready` drops after 8 words buffered (plus the word in `ram_req`); no word lost or reordered.
- WRITE_MEM with address 0x3FFFFF and 2 words: writes 0x3FFFFF then 0x000000.
- `start` after 3 of 10 payload words, then `0201,0000,0001`: 3 RAM writes complete, `reg_wr` with index 1 and data 0x00000001, remaining payload discarded.
- Header `7F00` then words: `err_cmd` pulses once, words dropped until `start`. Separately, `async_nreset` low mid-PAYLOAD: all outputs return to reset values.
